debug_sender: RTL and testbench

Transmit-side companion of the debug control unit. When the controller raises `send_flag` (after a halt or a single step), this block reads the PC, every register and a window of data memory. It serializes each 32-bit word into four bytes for the UART transmitter, paced by that transmitter's `tx_done`. It pulses `send_done` when the last byte has gone out, so the controller can return to mode reception or program reception.

---
 rtl/debug_pkg.sv | 22 ++
 rtl/debug_word_shifter.sv | 45 ++++
 rtl/debug_sender.sv | 154 +++++++++++++++
 tb/tb_debug_sender.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit: sender state encoding and the
// protocol words exchanged with the debug controller.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5,
        ST_HOLD  = 3'd6
    } sender_state_t;

    // Words recognised by the controller on the receive side.
    localparam logic [31:0] END_OF_PROGRAM_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] STEP_MODE_WORD      = 32'h1000_1000;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/debug_word_shifter.sv
// 32-bit word serializer: loads a word, shifts it left one byte at a time
// and flags the fourth byte of the word.
module debug_word_shifter
    import debug_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        shift_i,
    input  logic [31:0] word_i,
    output logic [7:0]  msb_byte_o,
    output logic        last_byte_o
);

    logic [31:0]           shift_q, shift_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

    // Load has priority; a shift also advances the byte counter.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shift_d = word_i;
            cnt_d   = '0;
        end else if (shift_i) begin
            shift_d = {shift_q[23:0], 8'h00};
            cnt_d   = cnt_q + BYTE_CNT_W'(1);
        end
    end

    // Shift register and byte counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign msb_byte_o  = shift_q[31:24];
    assign last_byte_o = (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/debug_sender.sv
// Dumps PC, register file and a data-memory window to the UART TX as a
// stream of bytes (MSB first per word), paced by tx_done.
module debug_sender
    import debug_pkg::*;
#(
    parameter int NBITS           = 32,
    parameter int NREGS           = 32,
    parameter int REG_ADDR_LENGTH = 5,
    parameter int DM_WORDS        = 32,
    parameter int DM_ADDR_LENGTH  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       send_flag,
    input  logic                       tx_done,
    input  logic [NBITS-1:0]           pc_value,
    input  logic [NBITS-1:0]           reg_data,
    input  logic [NBITS-1:0]           dm_data,
    output logic [REG_ADDR_LENGTH-1:0] reg_addr,
    output logic [DM_ADDR_LENGTH-1:0]  dm_addr,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       send_done
);

    localparam int NITEMS = 1 + NREGS + DM_WORDS;
    localparam int IDX_W  = $clog2(NITEMS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NITEMS - 1);
    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(NREGS);

    sender_state_t              state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [REG_ADDR_LENGTH-1:0] reg_addr_q, reg_addr_d;
    logic [DM_ADDR_LENGTH-1:0]  dm_addr_q, dm_addr_d;
    logic [7:0]                 tx_data_q, tx_data_d;

    logic [NBITS-1:0] sel_word;
    logic             shifter_load;
    logic             shifter_shift;
    logic [7:0]       msb_byte;
    logic             last_byte;

    debug_word_shifter u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (shifter_load),
        .shift_i     (shifter_shift),
        .word_i      (sel_word),
        .msb_byte_o  (msb_byte),
        .last_byte_o (last_byte)
    );

    // Pick the word belonging to the current item: PC, register, or DM.
    always_comb begin
        if (idx_q == '0) begin
            sel_word = pc_value;
        end else if (idx_q <= REG_LAST) begin
            sel_word = reg_data;
        end else begin
            sel_word = dm_data;
        end
    end

    // Sequencer: next state, item index and shifter control.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shifter_load  = 1'b0;
        shifter_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (send_flag) begin
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            // Address is out this cycle; data is sampled in LATCH so a
            // synchronous-read memory has time to respond.
            ST_LOAD:  state_d = ST_LATCH;
            ST_LATCH: begin
                shifter_load = 1'b1;
                state_d      = ST_SEND;
            end
            ST_SEND:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    shifter_shift = 1'b1;
                    if (!last_byte) begin
                        state_d = ST_SEND;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE:  state_d = ST_HOLD;
            // Stay here until the controller drops its request, so a
            // still-high send_flag cannot start a second dump.
            ST_HOLD: begin
                if (!send_flag) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Debug read addresses follow the next item; unused ones sit at 0.
    always_comb begin
        reg_addr_d = '0;
        dm_addr_d  = '0;
        if (state_d inside {ST_LOAD, ST_LATCH, ST_SEND, ST_WAIT}) begin
            if (idx_d == '0) begin
                reg_addr_d = '0;
            end else if (idx_d <= REG_LAST) begin
                reg_addr_d = REG_ADDR_LENGTH'(idx_d - IDX_W'(1));
            end else begin
                dm_addr_d = DM_ADDR_LENGTH'(idx_d - IDX_W'(NREGS + 1));
            end
        end
    end

    // The byte on the wire is captured while SEND is active and held
    // afterwards, so tx_data stays put while the shifter moves on.
    always_comb begin
        tx_data_d = (state_q == ST_SEND) ? msb_byte : tx_data_q;
    end

    // State, index, address and held-byte registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            reg_addr_q <= '0;
            dm_addr_q  <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            reg_addr_q <= reg_addr_d;
            dm_addr_q  <= dm_addr_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign reg_addr  = reg_addr_q;
    assign dm_addr   = dm_addr_q;
    assign tx_data   = tx_data_d;
    assign tx_start  = (state_q == ST_SEND);
    assign send_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_debug_sender.sv
// Directed bench for debug_sender: default-size instance plus a DM_WORDS=4
// instance, a pacing UART model and a byte log.
module tb_debug_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, send_flag, tx_done, tx_done_resp, tx_done_spur;
    logic [31:0] pc_value, reg_data, dm_data, dm_addr;
    logic [4:0]  reg_addr;
    logic        tx_start, send_done;
    logic [7:0]  tx_data;

    logic        send_flag2, tx_done2;
    logic [31:0] reg_data2, dm_data2, dm_addr2;
    logic [4:0]  reg_addr2;
    logic        tx_start2, send_done2;
    logic [7:0]  tx_data2;

    assign tx_done   = tx_done_resp | tx_done_spur;
    assign reg_data  = {27'd0, reg_addr} * 32'h0101_0101;
    assign dm_data   = 32'hA500_0000 | dm_addr;
    assign reg_data2 = {27'd0, reg_addr2} * 32'h0101_0101;
    assign dm_data2  = 32'hA500_0000 | dm_addr2;

    debug_sender #(.NBITS(32), .NREGS(32), .REG_ADDR_LENGTH(5),
                   .DM_WORDS(32), .DM_ADDR_LENGTH(32)) dut (
        .clk(clk), .reset(reset), .send_flag(send_flag), .tx_done(tx_done),
        .pc_value(pc_value), .reg_data(reg_data), .dm_data(dm_data),
        .reg_addr(reg_addr), .dm_addr(dm_addr), .tx_start(tx_start),
        .tx_data(tx_data), .send_done(send_done)
    );

    debug_sender #(.NBITS(32), .NREGS(32), .REG_ADDR_LENGTH(5),
                   .DM_WORDS(4), .DM_ADDR_LENGTH(32)) dut_small (
        .clk(clk), .reset(reset), .send_flag(send_flag2), .tx_done(tx_done2),
        .pc_value(pc_value), .reg_data(reg_data2), .dm_data(dm_data2),
        .reg_addr(reg_addr2), .dm_addr(dm_addr2), .tx_start(tx_start2),
        .tx_data(tx_data2), .send_done(send_done2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] log_byte [0:2047];
    int         log_cyc  [0:2047];
    int         nbytes = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         last_txd_cyc = 0;

    // Expected byte n of a dump: PC=0x40, reg[i]=i*0x01010101, dm[j]=0xA5000000|j.
    function automatic logic [7:0] exp_byte(input int n);
        int item;
        int b;
        logic [31:0] w;
        logic [31:0] s;
        item = n / 4;
        b    = n % 4;
        if (item == 0)       w = 32'h0000_0040;
        else if (item <= 32) w = (item - 1) * 32'h0101_0101;
        else                 w = 32'hA500_0000 | (item - 33);
        s = w >> (8 * (3 - b));
        return s[7:0];
    endfunction

    // Byte log and send_done monitor for the default instance.
    initial forever begin
        @(negedge clk);
        if (tx_start === 1'b1 && nbytes < 2048) begin
            log_byte[nbytes] = tx_data;
            log_cyc[nbytes]  = cyc;
            nbytes++;
        end
        if (send_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // UART model: tx_done 10 cycles after each tx_start.
    initial begin
        int cd;
        cd = 0;
        tx_done_resp = 1'b0;
        forever begin
            @(negedge clk);
            tx_done_resp = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    tx_done_resp = 1'b1;
                    last_txd_cyc = cyc;
                end
            end
            if (tx_start === 1'b1) cd = 10;
        end
    end

    task automatic wait_done(input int dc0, input int budget, output bit ok);
        for (int k = 0; k < budget && done_cnt == dc0; k++) @(negedge clk);
        ok = (done_cnt != dc0);
    endtask

    task automatic test_reset();
        int n0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_start, send_done, tx_data, reg_addr, dm_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state: got start=%b done=%b data=%h ra=%h da=%h, want all 0",
                     tx_start, send_done, tx_data, reg_addr, dm_addr);
        end
        reset = 1'b0;
        n0 = nbytes;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({tx_start, send_done, tx_data, reg_addr, dm_addr,
                 tx_start2, send_done2, tx_data2} !== '0) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d: got start=%b done=%b data=%h ra=%h da=%h, want all 0",
                         i, tx_start, send_done, tx_data, reg_addr, dm_addr);
            end
        end
        checks++;
        if (nbytes !== n0) begin
            errors++;
            $display("FAIL idle_no_start: got %0d bytes, want 0", nbytes - n0);
        end
    endtask

    // Checks a completed 260-byte dump in the log starting at base.
    task automatic check_dump(input string name, input int base, input int dc0, input bit ok);
        int bad;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: send_done not seen, want one pulse", name);
        end
        checks++;
        if (nbytes - base !== 260) begin
            errors++;
            $display("FAIL %s_count: got %0d bytes, want 260", name, nbytes - base);
        end
        bad = 0;
        for (int i = 0; i < 260; i++)
            if (log_byte[base + i] !== exp_byte(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_bytes: got %0d wrong bytes, want 0", name, bad);
        end
        checks++;
        if (done_cnt - dc0 !== 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d, want 1", name, done_cnt - dc0);
        end
        checks++;
        if (done_cyc !== last_txd_cyc + 1) begin
            errors++;
            $display("FAIL %s_done_timing: got cycle %0d, want %0d", name, done_cyc, last_txd_cyc + 1);
        end
    endtask

    task automatic test_full_dump();
        int base, dc0, t;
        bit ok;
        logic [7:0] head [0:11];
        logic [7:0] tail [0:3];
        head = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h01, 8'h01, 8'h01, 8'h01};
        tail = '{8'hA5, 8'h00, 8'h00, 8'h1F};
        base = nbytes;
        dc0  = done_cnt;
        @(negedge clk);
        send_flag = 1'b1;
        t = cyc;
        wait_done(dc0, 20000, ok);
        repeat (2) @(negedge clk);
        check_dump("full_dump", base, dc0, ok);
        checks++;
        if (log_cyc[base] !== t + 3) begin
            errors++;
            $display("FAIL first_start_latency: got cycle %0d, want %0d", log_cyc[base], t + 3);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (log_byte[base + i] !== head[i]) begin
                errors++;
                $display("FAIL head_byte %0d: got %h, want %h", i, log_byte[base + i], head[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_byte[base + 256 + i] !== tail[i]) begin
                errors++;
                $display("FAIL tail_byte %0d: got %h, want %h", i, log_byte[base + 256 + i], tail[i]);
            end
        end
        checks++;
        if (reg_addr !== 5'd0 || dm_addr !== 32'd0) begin
            errors++;
            $display("FAIL addr_after_dump: got ra=%h da=%h, want 0", reg_addr, dm_addr);
        end
    endtask

    task automatic test_back_to_back();
        int n0, dc0, base;
        bit ok;
        // send_flag is still high from the previous dump.
        n0  = nbytes;
        dc0 = done_cnt;
        repeat (30) @(negedge clk);
        checks++;
        if (nbytes !== n0 || done_cnt !== dc0) begin
            errors++;
            $display("FAIL no_retrigger: got %0d bytes %0d done, want 0 and 0",
                     nbytes - n0, done_cnt - dc0);
        end
        send_flag = 1'b0;
        repeat (3) @(negedge clk);
        base = nbytes;
        send_flag = 1'b1;
        for (int k = 0; k < 100 && nbytes == base; k++) @(negedge clk);
        send_flag = 1'b0;   // dropped mid-dump: must not stop it
        wait_done(dc0, 20000, ok);
        repeat (2) @(negedge clk);
        check_dump("second_dump", base, dc0, ok);
    endtask

    task automatic test_reset_mid_dump();
        int base, dc0;
        bit ok;
        base = nbytes;
        send_flag = 1'b1;
        for (int k = 0; k < 5000 && nbytes - base < 100; k++) @(negedge clk);
        #2;
        reset = 1'b1;
        send_flag = 1'b0;
        #1;
        checks++;
        if ({tx_start, send_done, tx_data, reg_addr, dm_addr} !== '0) begin
            errors++;
            $display("FAIL reset_mid_dump: got start=%b done=%b data=%h ra=%h da=%h, want all 0",
                     tx_start, send_done, tx_data, reg_addr, dm_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (nbytes - base !== 100) begin
            errors++;
            $display("FAIL reset_abort: got %0d bytes, want 100", nbytes - base);
        end
        base = nbytes;
        dc0  = done_cnt;
        send_flag = 1'b1;
        wait_done(dc0, 20000, ok);
        send_flag = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (log_byte[base] !== 8'h00) begin
            errors++;
            $display("FAIL restart_first_byte: got %h, want 00", log_byte[base]);
        end
        check_dump("restart_dump", base, dc0, ok);
    endtask

    task automatic test_spurious_tx_done();
        int base, dc0, t;
        bit ok;
        base = nbytes;
        dc0  = done_cnt;
        @(negedge clk);
        // tx_done held through IDLE, LOAD, LATCH and the first SEND cycle.
        send_flag    = 1'b1;
        tx_done_spur = 1'b1;
        t = cyc;
        repeat (4) @(negedge clk);
        tx_done_spur = 1'b0;
        wait_done(dc0, 20000, ok);
        send_flag = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (log_cyc[base] !== t + 3) begin
            errors++;
            $display("FAIL spurious_first_start: got cycle %0d, want %0d", log_cyc[base], t + 3);
        end
        check_dump("spurious", base, dc0, ok);
    endtask

    task automatic test_small_dm();
        logic [7:0] b2 [0:255];
        int nb, ndone, cd, bad, addr_bad, dm_seen;
        nb = 0; ndone = 0; cd = 0; addr_bad = 0; dm_seen = 0;
        @(negedge clk);
        send_flag2 = 1'b1;
        for (int k = 0; k < 5000 && ndone == 0; k++) begin
            @(negedge clk);
            tx_done2 = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) tx_done2 = 1'b1;
            end
            if (tx_start2 === 1'b1) begin
                if (nb < 256) b2[nb] = tx_data2;
                if (nb / 4 >= 33 && nb % 4 == 0) begin
                    dm_seen++;
                    if (dm_addr2 !== 32'(nb / 4 - 33) || reg_addr2 !== 5'd0) addr_bad++;
                end
                nb++;
                cd = 10;
            end
            if (send_done2 === 1'b1) ndone++;
        end
        tx_done2   = 1'b0;
        send_flag2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (send_done2 === 1'b1) ndone++;
        end
        checks++;
        if (nb !== 148) begin
            errors++;
            $display("FAIL small_count: got %0d bytes, want 148", nb);
        end
        bad = 0;
        for (int i = 0; i < 148 && i < nb; i++)
            if (b2[i] !== exp_byte(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL small_bytes: got %0d wrong bytes, want 0", bad);
        end
        checks++;
        if (addr_bad != 0 || dm_seen != 4) begin
            errors++;
            $display("FAIL small_dm_addr_seq: got %0d bad of %0d words, want 0 bad of 4",
                     addr_bad, dm_seen);
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL small_done_pulses: got %0d, want 1", ndone);
        end
        checks++;
        if (dm_addr2 !== 32'd0) begin
            errors++;
            $display("FAIL small_dm_addr_idle: got %0d, want 0", dm_addr2);
        end
    endtask

    initial begin
        reset        = 1'b1;
        send_flag    = 1'b0;
        tx_done_spur = 1'b0;
        send_flag2   = 1'b0;
        tx_done2     = 1'b0;
        pc_value     = 32'h0000_0040;
        test_reset();
        test_full_dump();
        test_back_to_back();
        test_reset_mid_dump();
        test_spurious_tx_done();
        test_small_dm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
